munoc_w_downsize_sequencer: RTL

- Sequences AXI write-data beats from a wide upstream W channel onto a narrow downstream W channel, one narrow beat per handshake.
- Tracks the active narrow byte-lane and the narrow beat count for each burst. Pops a wide beat only when all of its addressed lanes have been sent.
- Sits in the MUNOC width-converter path after the AW converter, which supplies the start address low bits and the already-converted narrow burst length.
- Data steering is combinational through ERVP_MUX; all control is registered.

---
 rtl/munoc_wconv_pkg.sv | 40 ++++
 rtl/ervp_mux.sv | 25 ++
 rtl/munoc_lane_counter.sv | 79 +++++++
 rtl/munoc_w_downsize_sequencer.sv | 122 ++++++++++++
 4 files changed

// File: rtl/munoc_wconv_pkg.sv
// rtl/munoc_wconv_pkg.sv - shared definitions for the MUNOC W-channel width converter
// Contents: AXI burst encodings, sequencer state encoding, and width-derivation
// helpers (lane count, lane select width, byte-offset width).
package munoc_wconv_pkg;

   localparam logic [1:0] BURST_FIXED = 2'd0;
   localparam logic [1:0] BURST_INCR  = 2'd1;
   localparam logic [1:0] BURST_WRAP  = 2'd2;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } wconv_state_t;

   // Ceiling log2; log2ru(1) = 0.
   function automatic int log2ru(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

   function automatic int calc_ratio(input int bw_wide, input int bw_narrow);
      return bw_wide / bw_narrow;
   endfunction

   // The lane select is kept at least one bit wide so RATIO=1 still has a legal port.
   function automatic int calc_bw_lane(input int ratio);
      return (log2ru(ratio) < 1) ? 1 : log2ru(ratio);
   endfunction

   function automatic int calc_bw_offset(input int bw_wide);
      return log2ru(bw_wide / 8);
   endfunction

endpackage

// File: rtl/ervp_mux.sv
// rtl/ervp_mux.sv - one-of-N word selector used for lane steering
// Ports:
//   data_i  NUM_DATA packed words, word 0 in the least significant bits
//   sel_i   word index
//   data_o  selected word (zero if sel_i is out of range)
module ERVP_MUX #(
   parameter int BW_DATA  = 32,
   parameter int NUM_DATA = 2,
   parameter int BW_SEL   = 1
) (
   input  logic [NUM_DATA*BW_DATA-1:0] data_i,
   input  logic [BW_SEL-1:0]           sel_i,
   output logic [BW_DATA-1:0]          data_o
);

   always_comb begin
      data_o = '0;
      for (int i = 0; i < NUM_DATA; i++) begin
         if (sel_i == BW_SEL'(i)) begin
            data_o = data_i[i*BW_DATA +: BW_DATA];
         end
      end
   end

endmodule

// File: rtl/munoc_lane_counter.sv
// rtl/munoc_lane_counter.sv - narrow lane and beat counters with last/pop decode
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   load_i            start a new burst with the load_* values
//   load_lane_i       starting narrow lane
//   load_len_i        narrow beats minus 1
//   load_fixed_i      FIXED burst: lane never advances
//   step_i            one narrow beat handshaken
//   lane_o            current narrow lane
//   last_o            current narrow beat is the last of the burst
//   pop_o             current narrow beat is the final use of the wide beat
module munoc_lane_counter
   import munoc_wconv_pkg::*;
#(
   parameter int RATIO      = 2,
   parameter int BW_LANE    = 1,
   parameter int BW_AXI_LEN = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  load_i,
   input  logic [BW_LANE-1:0]    load_lane_i,
   input  logic [BW_AXI_LEN-1:0] load_len_i,
   input  logic                  load_fixed_i,
   input  logic                  step_i,
   output logic [BW_LANE-1:0]    lane_o,
   output logic                  last_o,
   output logic                  pop_o
);

   localparam logic [BW_LANE-1:0] LANE_MAX = BW_LANE'(RATIO - 1);

   logic [BW_LANE-1:0]    lane_q, lane_d;
   logic [BW_AXI_LEN-1:0] beat_cnt_q, beat_cnt_d;
   logic [BW_AXI_LEN-1:0] len_q, len_d;
   logic                  fixed_q, fixed_d;

   assign lane_o = lane_q;
   assign last_o = (beat_cnt_q == len_q);
   assign pop_o  = fixed_q || (lane_q == LANE_MAX) || last_o;

   always_comb begin
      lane_d     = lane_q;
      beat_cnt_d = beat_cnt_q;
      len_d      = len_q;
      fixed_d    = fixed_q;
      // A load coincides with a step only on the last beat, so load wins.
      if (load_i) begin
         lane_d     = (RATIO == 1) ? '0 : load_lane_i;
         beat_cnt_d = '0;
         len_d      = load_len_i;
         fixed_d    = load_fixed_i;
      end else if (step_i) begin
         // Holding at len keeps a 256-beat burst from wrapping the counter.
         if (!last_o) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
         end
         // Lane width equals log2(RATIO), so the add wraps modulo RATIO.
         if (!fixed_q && RATIO > 1) begin
            lane_d = lane_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lane_q     <= '0;
         beat_cnt_q <= '0;
         len_q      <= '0;
         fixed_q    <= 1'b0;
      end else begin
         lane_q     <= lane_d;
         beat_cnt_q <= beat_cnt_d;
         len_q      <= len_d;
         fixed_q    <= fixed_d;
      end
   end

endmodule

// File: rtl/munoc_w_downsize_sequencer.sv
// rtl/munoc_w_downsize_sequencer.sv - wide-to-narrow AXI W beat sequencer
// Ports:
//   clk_i, rst_i                   clock, synchronous active-high reset
//   cmd_valid_i/cmd_ready_o        burst command handshake
//   cmd_addr_i                     start byte offset within the wide word
//   cmd_len_i                      narrow beats minus 1
//   cmd_burst_i                    AXI burst type (WRAP handled as INCR)
//   s_w*_i / s_wready_o            wide upstream W channel
//   m_w*_o / m_wready_i            narrow downstream W channel
//   busy_o                         burst in progress
//   err_wlast_o                    one-cycle pulse: s_wlast disagreed with m_wlast on a pop
module munoc_w_downsize_sequencer
   import munoc_wconv_pkg::*;
#(
   parameter int  BW_WIDE_DATA   = 64,
   parameter int  BW_NARROW_DATA = 32,
   parameter int  BW_AXI_LEN     = 8,
   localparam int RATIO          = calc_ratio(BW_WIDE_DATA, BW_NARROW_DATA),
   localparam int BW_LANE        = calc_bw_lane(RATIO),
   localparam int BW_OFFSET      = calc_bw_offset(BW_WIDE_DATA)
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        cmd_valid_i,
   output logic                        cmd_ready_o,
   input  logic [BW_OFFSET-1:0]        cmd_addr_i,
   input  logic [BW_AXI_LEN-1:0]       cmd_len_i,
   input  logic [1:0]                  cmd_burst_i,
   input  logic                        s_wvalid_i,
   output logic                        s_wready_o,
   input  logic [BW_WIDE_DATA-1:0]     s_wdata_i,
   input  logic [BW_WIDE_DATA/8-1:0]   s_wstrb_i,
   input  logic                        s_wlast_i,
   output logic                        m_wvalid_o,
   input  logic                        m_wready_i,
   output logic [BW_NARROW_DATA-1:0]   m_wdata_o,
   output logic [BW_NARROW_DATA/8-1:0] m_wstrb_o,
   output logic                        m_wlast_o,
   output logic                        busy_o,
   output logic                        err_wlast_o
);

   wconv_state_t       state_q, state_d;
   logic               err_wlast_q, err_wlast_d;
   logic [BW_LANE-1:0] lane;
   logic               last, pop;
   logic               active, step, last_hs, cmd_hs;
   logic               unused_addr;

   // Address bits below the narrow lane only matter to the strobes upstream.
   assign unused_addr = ^cmd_addr_i;

   // Gating with rst_i keeps the handshakes quiet during the reset cycle itself.
   assign active      = (state_q == ST_ACTIVE) && !rst_i;
   assign m_wvalid_o  = active && s_wvalid_i;
   assign m_wlast_o   = last;
   assign s_wready_o  = active && m_wready_i && pop;
   assign step        = m_wvalid_o && m_wready_i;
   assign last_hs     = step && m_wlast_o;
   assign cmd_ready_o = !rst_i && ((state_q == ST_IDLE) || last_hs);
   assign cmd_hs      = cmd_valid_i && cmd_ready_o;
   assign busy_o      = (state_q == ST_ACTIVE);
   assign err_wlast_o = err_wlast_q;

   always_comb begin
      state_d     = state_q;
      err_wlast_d = s_wvalid_i && s_wready_o && (s_wlast_i != m_wlast_o);
      if (cmd_hs) begin
         state_d = ST_ACTIVE;
      end else if (last_hs) begin
         state_d = ST_IDLE;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         err_wlast_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         err_wlast_q <= err_wlast_d;
      end
   end

   munoc_lane_counter #(
      .RATIO      (RATIO),
      .BW_LANE    (BW_LANE),
      .BW_AXI_LEN (BW_AXI_LEN)
   ) u_lane_counter (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .load_i       (cmd_hs),
      .load_lane_i  (cmd_addr_i[BW_OFFSET-1 -: BW_LANE]),
      .load_len_i   (cmd_len_i),
      .load_fixed_i (cmd_burst_i == BURST_FIXED),
      .step_i       (step),
      .lane_o       (lane),
      .last_o       (last),
      .pop_o        (pop)
   );

   ERVP_MUX #(
      .BW_DATA  (BW_NARROW_DATA),
      .NUM_DATA (RATIO),
      .BW_SEL   (BW_LANE)
   ) u_data_mux (
      .data_i (s_wdata_i),
      .sel_i  (lane),
      .data_o (m_wdata_o)
   );

   ERVP_MUX #(
      .BW_DATA  (BW_NARROW_DATA/8),
      .NUM_DATA (RATIO),
      .BW_SEL   (BW_LANE)
   ) u_strb_mux (
      .data_i (s_wstrb_i),
      .sel_i  (lane),
      .data_o (m_wstrb_o)
   );

endmodule
